// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath widths, the NOP encoding and the instruction field layout.
package cpu_defs;

  localparam int ADDR_W = 6;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0;

  // Fetch buffer occupancy encodings
  localparam logic [1:0] BUF_EMPTY = 2'd0;
  localparam logic [1:0] BUF_ONE   = 2'd1;
  localparam logic [1:0] BUF_FULL  = 2'd2;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] func;
    logic [4:0] imm;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
  } inst_fields_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer; the head register always drives the output, with no bypass path.
module fetch_fifo
  import cpu_defs::*;
#(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      count_d = BUF_EMPTY;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == BUF_EMPTY) begin
            head_d  = data_i;
            count_d = BUF_ONE;
          end else if (count_q == BUF_ONE) begin
            tail_d  = data_i;
            count_d = BUF_FULL;
          end
        end
        2'b01: begin
          if (count_q != BUF_EMPTY) begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
          end
        end
        2'b11: begin
          // Simultaneous push and pop keeps occupancy and shifts the new word in behind the old tail
          if (count_q == BUF_FULL) begin
            head_d = tail_q;
            tail_d = data_i;
          end else begin
            head_d  = data_i;
            count_d = BUF_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= BUF_EMPTY;
    end else begin
      count_q <= count_d;
    end
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC register, redirect handling, fetch buffer and fetched-instruction counter.
module inst_fetch_unit
  import cpu_defs::*;
#(
  parameter int                ADDR_W   = cpu_defs::ADDR_W,
  parameter int                INST_W   = cpu_defs::INST_W,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [CNT_W-1:0]  fetch_cnt
);

  localparam int ENT_W = ADDR_W + INST_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ENT_W-1:0]  head;
  logic [1:0]        count;
  logic              push, pop;

  assign pop  = id_valid & id_ready;
  assign push = ~redirect_valid & ((count != BUF_FULL) | pop);

  // Redirect wins over sequential fetch; the buffer flush is driven from the same signal
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (push) begin
      pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= PC_RESET;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  fetch_fifo #(
    .W(ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_i  ({pc_q, rom_inst}),
    .head_o  (head),
    .count_o (count)
  );

  assign rom_addr  = pc_q;
  assign id_valid  = (count != BUF_EMPTY);
  assign id_inst   = id_valid ? head[INST_W-1:0] : NOP_INST;
  assign id_pc     = id_valid ? head[ENT_W-1:INST_W] : '0;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [5:0]        rom_addr;
  logic [31:0]       rom_inst;
  logic              redirect_valid;
  logic [5:0]        redirect_pc;
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_inst;
  logic [5:0]        id_pc;
  logic [CNT_W-1:0]  fetch_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [5:0]  m_pc = '0;
  int          m_cnt = 0;
  int          pops = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .ADDR_W  (6),
    .INST_W  (32),
    .PC_RESET(6'h00),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_addr      (rom_addr),
    .rom_inst      (rom_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_inst       (id_inst),
    .id_pc         (id_pc),
    .fetch_cnt     (fetch_cnt)
  );

  function automatic logic [31:0] rom_word(input logic [5:0] a);
    return (a == 6'd1) ? 32'h00100443 : {26'h0, a};
  endfunction

  always_comb rom_inst = rom_word(rom_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    chk("id_valid", 64'(id_valid), 64'(mq.size() > 0));
    chk("id_pc", 64'(id_pc), (mq.size() > 0) ? 64'(mq[0].pc) : 64'd0);
    chk("id_inst", 64'(id_inst), (mq.size() > 0) ? 64'(mq[0].inst) : 64'd0);
    chk("rom_addr", 64'(rom_addr), 64'(m_pc));
    chk("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
  endtask

  // Drive one cycle of inputs, advance the reference model across the edge, then compare.
  task automatic step(input logic rdy, input logic rv, input logic [5:0] rp, input logic r);
    logic pop;
    logic push;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
    rst            = r;
    if (r) begin
      mq.delete();
      m_pc  = 6'h00;
      m_cnt = 0;
    end else begin
      pop = (mq.size() > 0) && rdy;
      if (pop) pops++;
      if (rv) begin
        mq.delete();
        m_pc = rp;
      end else begin
        push = (mq.size() < 2) || pop;
        if (pop) void'(mq.pop_front());
        if (push) begin
          mq.push_back('{pc: m_pc, inst: rom_word(m_pc)});
          m_pc = m_pc + 6'd1;
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
    compare_model();
  endtask

  initial begin
    rst = 1'b1;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    // Reset state
    step(1'b0, 1'b0, 6'h00, 1'b1);
    step(1'b0, 1'b0, 6'h00, 1'b1);
    chk("reset_valid", 64'(id_valid), 64'd0);
    chk("reset_addr", 64'(rom_addr), 64'd0);

    // Streaming with decode always ready
    step(1'b1, 1'b0, 6'h00, 1'b0);
    chk("first_valid", 64'(id_valid), 64'd1);
    chk("first_inst", 64'(id_inst), 64'h0);
    step(1'b1, 1'b0, 6'h00, 1'b0);
    chk("second_inst", 64'(id_inst), 64'h00100443);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 6'h00, 1'b0);

    // Stall after reset, then release
    step(1'b0, 1'b0, 6'h00, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 6'h00, 1'b0);
    chk("stall_addr", 64'(rom_addr), 64'd2);
    chk("stall_head", 64'(id_pc), 64'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 6'h00, 1'b0);

    // Redirect to 0x3E while full, including the wrap to 0
    step(1'b0, 1'b0, 6'h00, 1'b0);
    step(1'b0, 1'b0, 6'h00, 1'b0);
    step(1'b1, 1'b1, 6'h3E, 1'b0);
    chk("redir_valid", 64'(id_valid), 64'd0);
    step(1'b1, 1'b0, 6'h00, 1'b0);
    chk("redir_head", 64'(id_pc), 64'h3E);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 6'h00, 1'b0);

    // Toggling ready with pops+occupancy bookkeeping from a fresh reset
    step(1'b0, 1'b0, 6'h00, 1'b1);
    pops = 0;
    for (int i = 0; i < 40; i++) begin
      step(logic'(i % 2), 1'b0, 6'h00, 1'b0);
      chk("cnt_balance", 64'(fetch_cnt),
          64'((pops + mq.size() > 15) ? 15 : pops + mq.size()));
    end

    // Reset wins over a simultaneous redirect while full
    step(1'b0, 1'b0, 6'h00, 1'b0);
    step(1'b0, 1'b0, 6'h00, 1'b0);
    step(1'b1, 1'b1, 6'h20, 1'b1);
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_addr", 64'(rom_addr), 64'd0);
    chk("rst_cnt", 64'(fetch_cnt), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 6'h00, 1'b0);

    // Back-to-back redirects: only the second target stream survives
    step(1'b1, 1'b1, 6'd5, 1'b0);
    step(1'b1, 1'b1, 6'd9, 1'b0);
    step(1'b1, 1'b0, 6'h00, 1'b0);
    chk("redir2_head", 64'(id_pc), 64'd9);
    step(1'b1, 1'b0, 6'h00, 1'b0);
    chk("redir2_next", 64'(id_pc), 64'd10);

    // Random ready/redirect traffic
    for (int i = 0; i < 120; i++) begin
      step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 7) == 0),
           6'($urandom_range(0, 63)), logic'($urandom_range(0, 39) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
